// File: rtl/keccak_arb_pkg.sv
// Shared types and constants for the KeccakF1600 permutation arbiter.
// The optional watchdog is enabled with the KECCAK_ARB_WDOG_EN macro.
package keccak_arb_pkg;

    localparam int STATE_WIDTH_DEF = 1600;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } fsm_e;

    // Width of a client index; a single client still needs one bit.
    function automatic int grant_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority selector: the search starts one past the
// last served index and wraps, so the most recently served client is last.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_last,
    output logic [N-1:0]  o_grant,
    output logic [IW-1:0] o_idx,
    output logic          o_any
);

    // w_cand[gi] is the client examined at priority step gi (0 = highest).
    logic [IW-1:0] w_cand [N];

    genvar gi;
    for (gi = 0; gi < N; gi++) begin : g_cand
        assign w_cand[gi] = IW'((int'(i_last) + gi + 1) % N);
    end

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        // Walk from lowest to highest priority so the highest-priority hit sticks.
        for (int k = N - 1; k >= 0; k--) begin
            if (i_req[w_cand[k]]) begin
                o_idx = w_cand[k];
                o_any = 1'b1;
            end
        end
        if (o_any) begin
            o_grant[o_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/keccak_perm_arbiter.sv
// Round-robin sharing of one KeccakF1600 core between NUM_REQ sponge clients.
// Define KECCAK_ARB_WDOG_EN to abort permutations that exceed WDOG_CYCLES.
module keccak_perm_arbiter
    import keccak_arb_pkg::*;
#(
    parameter int STATE_WIDTH = STATE_WIDTH_DEF,
    parameter int NUM_REQ     = 4,
    parameter int WDOG_CYCLES = 64
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [NUM_REQ-1:0]                 req_valid,
    input  logic [NUM_REQ*STATE_WIDTH-1:0]     req_state,
    output logic [NUM_REQ-1:0]                 req_ready,
    output logic [NUM_REQ-1:0]                 rsp_valid,
    input  logic [NUM_REQ-1:0]                 rsp_ready,
    output logic [STATE_WIDTH-1:0]             rsp_state,
    output logic                               rsp_err,
    output logic                               perm_start,
    output logic [STATE_WIDTH-1:0]             perm_state_in,
    input  logic [STATE_WIDTH-1:0]             perm_state_out,
    input  logic                               perm_done,
    output logic                               busy,
    output logic [grant_width(NUM_REQ)-1:0]    debug_grant
);

    localparam int GW = grant_width(NUM_REQ);

    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_WAIT = WAIT;
    localparam logic [1:0] S_RESP = RESP;

    if (NUM_REQ < 2 || NUM_REQ > 8 || WDOG_CYCLES < 1) begin : g_bad_cfg
        $error("keccak_perm_arbiter: NUM_REQ must be 2..8 and WDOG_CYCLES >= 1");
    end

    logic [1:0]             r_fsm;
    logic [GW-1:0]          r_grant;
    logic [GW-1:0]          r_last_grant;
    logic                   r_perm_start;
    logic [STATE_WIDTH-1:0] r_perm_state_in;
    logic [STATE_WIDTH-1:0] r_rsp_state;
    logic [NUM_REQ-1:0]     r_rsp_valid;

    logic [STATE_WIDTH-1:0] w_req_state [NUM_REQ];
    logic [NUM_REQ-1:0]     w_rsp_oh;
    logic [NUM_REQ-1:0]     w_arb_grant;
    logic [GW-1:0]          w_sel_idx;
    logic                   w_any_req;

    genvar gi;
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_client
        assign w_req_state[gi] = req_state[gi*STATE_WIDTH +: STATE_WIDTH];
        assign w_rsp_oh[gi]    = (r_grant == GW'(gi));
    end

    rr_arbiter #(
        .N  (NUM_REQ),
        .IW (GW)
    ) u_rr_arbiter (
        .i_req   (req_valid),
        .i_last  (r_last_grant),
        .o_grant (w_arb_grant),
        .o_idx   (w_sel_idx),
        .o_any   (w_any_req)
    );

`ifdef KECCAK_ARB_WDOG_EN
    localparam int               WW        = $clog2(WDOG_CYCLES + 1);
    localparam logic [WW-1:0]    WDOG_LAST = WW'(WDOG_CYCLES - 1);

    logic [WW-1:0] r_wdog_cnt;
    logic          r_rsp_err;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fsm           <= S_IDLE;
            r_grant         <= '0;
            r_last_grant    <= GW'(NUM_REQ - 1);
            r_perm_start    <= 1'b0;
            r_perm_state_in <= '0;
            r_rsp_state     <= '0;
            r_rsp_valid     <= '0;
`ifdef KECCAK_ARB_WDOG_EN
            r_wdog_cnt      <= '0;
            r_rsp_err       <= 1'b0;
`endif
        end else begin
            case (r_fsm)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_perm_state_in <= w_req_state[w_sel_idx];
                        r_grant         <= w_sel_idx;
                        r_perm_start    <= 1'b1;
                        r_fsm           <= S_WAIT;
`ifdef KECCAK_ARB_WDOG_EN
                        r_wdog_cnt      <= '0;
`endif
                    end
                end
                S_WAIT: begin
                    // A done arriving on the watchdog's last cycle still counts as success.
                    if (perm_done) begin
                        r_rsp_state  <= perm_state_out;
                        r_rsp_valid  <= w_rsp_oh;
                        r_perm_start <= 1'b0;
                        r_fsm        <= S_RESP;
                    end
`ifdef KECCAK_ARB_WDOG_EN
                    else if (r_wdog_cnt == WDOG_LAST) begin
                        r_rsp_state  <= '0;
                        r_rsp_err    <= 1'b1;
                        r_rsp_valid  <= w_rsp_oh;
                        r_perm_start <= 1'b0;
                        r_fsm        <= S_RESP;
                    end else begin
                        r_wdog_cnt <= r_wdog_cnt + 1'b1;
                    end
`endif
                end
                S_RESP: begin
                    if (rsp_ready[r_grant]) begin
                        r_rsp_valid  <= '0;
                        r_last_grant <= r_grant;
                        r_fsm        <= S_IDLE;
`ifdef KECCAK_ARB_WDOG_EN
                        r_rsp_err    <= 1'b0;
`endif
                    end
                end
                default: r_fsm <= S_IDLE;
            endcase
        end
    end

    assign req_ready     = (r_fsm == S_IDLE) ? w_arb_grant : '0;
    assign rsp_valid     = r_rsp_valid;
    assign rsp_state     = r_rsp_state;
    assign perm_start    = r_perm_start;
    assign perm_state_in = r_perm_state_in;
    assign busy          = (r_fsm != S_IDLE);
    assign debug_grant   = r_grant;

`ifdef KECCAK_ARB_WDOG_EN
    assign rsp_err = r_rsp_err;
`else
    assign rsp_err = 1'b0;
`endif

endmodule
